// File: rtl/claw_stepper_seq.sv
// claw_stepper_seq: step-counted drop / grab-pause / raise sequencer for the claw
// axis, driving a 4-wire bipolar stepper in full- or half-step excitation.
module claw_stepper_seq #(
  parameter int unsigned STEP_DELAY   = 1_000_000,
  parameter int unsigned DROP_STEPS   = 300,
  parameter int unsigned PAUSE_CYCLES = 100_000_000,
  parameter int unsigned STEPS_W      = 16,
  parameter int unsigned HOLD_IDLE    = 1
) (
  input  logic               CLK100MHZ,
  input  logic               reset,
  input  logic               go,
  input  logic               abort,
  input  logic               half_step,
  output logic [3:0]         coils,
  output logic               busy,
  output logic               done,
  output logic [STEPS_W-1:0] position
);

  localparam int unsigned TMR_W    = (STEP_DELAY > 1) ? $clog2(STEP_DELAY) : 1;
  localparam int unsigned PAUSE_W  = $clog2(PAUSE_CYCLES + 1);
  localparam logic [3:0]  IDLE_PAT = (HOLD_IDLE != 0) ? 4'b1001 : 4'b0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DESCEND,
    ST_PAUSE,
    ST_ASCEND,
    ST_DONE
  } state_t;

  state_t               r_state;
  logic [2:0]           r_ph;
  logic                 r_mode;
  logic                 r_go_prev;
  logic [TMR_W-1:0]     r_tmr;
  logic [PAUSE_W-1:0]   r_pause_cnt;

  logic [2:0]           w_inc;
  logic [2:0]           w_ph_dn;
  logic [2:0]           w_ph_up;
  logic                 w_step;
  logic                 w_trig;
  logic                 w_pause_end;
  logic                 w_at_top;

  // Excitation table, indexed by the phase register
  function automatic logic [3:0] phase_pat(input logic [2:0] p);
    case (p)
      3'd0:    phase_pat = 4'b1001;
      3'd1:    phase_pat = 4'b1000;
      3'd2:    phase_pat = 4'b1010;
      3'd3:    phase_pat = 4'b0010;
      3'd4:    phase_pat = 4'b0110;
      3'd5:    phase_pat = 4'b0100;
      3'd6:    phase_pat = 4'b0101;
      default: phase_pat = 4'b0001;
    endcase
  endfunction

  assign w_inc       = r_mode ? 3'd1 : 3'd2;
  assign w_ph_dn     = r_ph - w_inc;
  assign w_ph_up     = r_ph + w_inc;
  assign w_step      = (r_tmr == TMR_W'(STEP_DELAY - 1));
  assign w_trig      = r_go_prev & ~go;
  assign w_pause_end = (r_pause_cnt == PAUSE_W'(PAUSE_CYCLES));
  assign w_at_top    = (position == '0);

  // Sequencer; coils/busy/done are registered from the next-state values
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ph        <= 3'd0;
      r_mode      <= 1'b0;
      r_go_prev   <= 1'b0;
      r_tmr       <= '0;
      r_pause_cnt <= '0;
      position    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      coils       <= IDLE_PAT;
    end else begin
      r_go_prev <= go;
      case (r_state)
        ST_IDLE: begin
          if (w_trig) begin
            r_state <= ST_DESCEND;
            r_mode  <= half_step;
            r_tmr   <= '0;
            busy    <= 1'b1;
            coils   <= phase_pat(r_ph);
          end
        end
        ST_DESCEND: begin
          if (abort) begin
            if (!w_at_top) begin
              r_state <= ST_ASCEND;
              r_tmr   <= '0;
            end else begin
              r_state <= ST_DONE;
              done    <= 1'b1;
              coils   <= IDLE_PAT;
            end
          end else if (w_step) begin
            r_tmr    <= '0;
            r_ph     <= w_ph_dn;
            position <= position + STEPS_W'(1);
            coils    <= phase_pat(w_ph_dn);
            if (position == STEPS_W'(DROP_STEPS - 1)) begin
              r_state     <= ST_PAUSE;
              r_pause_cnt <= '0;
            end
          end else begin
            r_tmr <= r_tmr + TMR_W'(1);
          end
        end
        ST_PAUSE: begin
          // Pause occupies its entry cycle plus PAUSE_CYCLES counted cycles
          if (abort && w_at_top) begin
            r_state <= ST_DONE;
            done    <= 1'b1;
            coils   <= IDLE_PAT;
          end else if (abort || w_pause_end) begin
            r_state <= ST_ASCEND;
            r_tmr   <= '0;
          end else begin
            r_pause_cnt <= r_pause_cnt + PAUSE_W'(1);
          end
        end
        ST_ASCEND: begin
          if (w_step) begin
            r_tmr    <= '0;
            r_ph     <= w_ph_up;
            position <= position - STEPS_W'(1);
            if (position == STEPS_W'(1)) begin
              r_state <= ST_DONE;
              done    <= 1'b1;
              coils   <= IDLE_PAT;
            end else begin
              coils <= phase_pat(w_ph_up);
            end
          end else begin
            r_tmr <= r_tmr + TMR_W'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          coils   <= IDLE_PAT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_claw_stepper_seq.sv
// Bench for claw_stepper_seq: directed and randomized trips compared against a
// trip-level model (expected coil/position/timing events and busy length).
module tb_claw_stepper_seq;

  localparam int unsigned SD = 4;
  localparam int unsigned DS = 3;
  localparam int unsigned PC = 5;
  localparam int unsigned SW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          go = 1'b0;
  logic          abort = 1'b0;
  logic          half_step = 1'b0;
  logic [3:0]    coils, coils0;
  logic          busy, busy0, done, done0;
  logic [SW-1:0] position, position0;

  claw_stepper_seq #(.STEP_DELAY(SD), .DROP_STEPS(DS), .PAUSE_CYCLES(PC),
                     .STEPS_W(SW), .HOLD_IDLE(1)) u_dut (
    .CLK100MHZ(clk), .reset(reset), .go(go), .abort(abort), .half_step(half_step),
    .coils(coils), .busy(busy), .done(done), .position(position));

  claw_stepper_seq #(.STEP_DELAY(SD), .DROP_STEPS(DS), .PAUSE_CYCLES(PC),
                     .STEPS_W(SW), .HOLD_IDLE(0)) u_dut0 (
    .CLK100MHZ(clk), .reset(reset), .go(go), .abort(abort), .half_step(half_step),
    .coils(coils0), .busy(busy0), .done(done0), .position(position0));

  always #5 clk = ~clk;

  logic [3:0] tbl [8] = '{4'b1001, 4'b1000, 4'b1010, 4'b0010,
                          4'b0110, 4'b0100, 4'b0101, 4'b0001};

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Monitor: cycle stamp, busy/done tallies and a log of coil changes while busy
  int unsigned cyc = 0;
  int unsigned busy_cnt = 0;
  int unsigned done_cnt = 0;
  logic [3:0]  prev_coils = 4'b1001;
  logic [3:0]  ev_coils[$];
  int unsigned ev_pos[$];
  int unsigned ev_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (busy === 1'b1 && coils !== prev_coils) begin
      ev_coils.push_back(coils);
      ev_pos.push_back(32'(position));
      ev_cyc.push_back(cyc);
    end
    prev_coils <= coils;
  end

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One trip: ab = abort cycle index from DESCEND entry (-1 none); hold = abort
  // held high through ASCEND; second_go = extra go edge while busy
  task automatic run_trip(input bit m, input int ab, input bit hold, input bit second_go);
    int unsigned s_ev, s_busy, s_done, entry, k, asc_start, exp_busy, n_obs, n_cmp;
    int          ph, inc, got;
    logic [3:0]  e_coils[$];
    int unsigned e_pos[$];
    int unsigned e_cyc[$];

    s_ev   = ev_coils.size();
    s_busy = busy_cnt;
    s_done = done_cnt;
    half_step = m;
    @(posedge clk); #1;
    go = 1'b0;
    tick(1);
    entry = cyc;
    go = 1'b1;
    half_step = ~m;

    if (second_go) begin
      tick(5); go = 1'b0;
      tick(2); go = 1'b1;
    end
    if (ab >= 0) begin
      while (cyc < entry + 32'(ab)) tick(1);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
    end
    if (hold) begin
      while (cyc < entry + DS*SD + PC + 2) tick(1);
      abort = 1'b1;
    end

    got = 0;
    for (int i = 0; i < 200 && got == 0; i++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1;
    end
    check("done_seen", 32'(got), 1);
    if (got != 0) begin
      check("coils_in_done", 32'(coils), 32'(4'b1001));
      check("coils_in_done_hold0", 32'(coils0), 0);
      check("done0_pulse", 32'(done0), 1);
    end
    @(posedge clk); #1;
    abort = 1'b0;
    tick(2);

    // Reference: steps travelled k, then exactly k retract steps
    inc = m ? 1 : 2;
    if (ab < 0) begin
      k = DS;
      asc_start = DS*SD + PC + 1;
      exp_busy  = 2*DS*SD + PC + 2;
    end else begin
      k = 32'(ab) / SD;
      if (k > DS) k = DS;
      asc_start = 32'(ab) + 1;
      exp_busy  = (k == 0) ? 32'(ab) + 2 : 32'(ab) + 2 + k*SD;
    end
    ph = 0;
    for (int i = 1; i <= int'(k); i++) begin
      ph = (ph - inc) & 7;
      e_coils.push_back(tbl[ph]);
      e_pos.push_back(32'(i));
      e_cyc.push_back(entry + 32'(i)*SD);
    end
    for (int j = 1; j <= int'(k); j++) begin
      ph = (ph + inc) & 7;
      e_coils.push_back(tbl[ph]);
      e_pos.push_back(k - 32'(j));
      e_cyc.push_back(entry + asc_start + 32'(j)*SD);
    end

    n_obs = ev_coils.size() - s_ev;
    check("event_count", n_obs, e_coils.size());
    n_cmp = (n_obs < e_coils.size()) ? n_obs : e_coils.size();
    for (int i = 0; i < int'(n_cmp); i++) begin
      check($sformatf("ev%0d_coils", i), 32'(ev_coils[s_ev + i]), 32'(e_coils[i]));
      check($sformatf("ev%0d_pos", i), ev_pos[s_ev + i], e_pos[i]);
      check($sformatf("ev%0d_cycle", i), ev_cyc[s_ev + i] - entry, e_cyc[i] - entry);
    end
    check("busy_cycles", busy_cnt - s_busy, exp_busy);
    check("done_pulses", done_cnt - s_done, 1);
    check("end_coils", 32'(coils), 32'(4'b1001));
    check("end_coils_hold0", 32'(coils0), 0);
    check("end_position", 32'(position), 0);
    check("end_busy", 32'(busy), 0);
    check("end_position0", 32'(position0), 0);
    check("end_busy0", 32'(busy0), 0);
  endtask

  initial begin
    int unsigned s_ev, s_done;
    // go held low across reset and its release
    tick(3);
    check("rst_coils", 32'(coils), 32'(4'b1001));
    check("rst_coils_hold0", 32'(coils0), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_position", 32'(position), 0);
    reset = 1'b0;
    tick(10);
    check("go_low_thru_reset_busy", 32'(busy), 0);
    check("go_low_thru_reset_events", ev_coils.size(), 0);
    check("go_low_thru_reset_done", done_cnt, 0);
    go = 1'b1;
    tick(2);

    run_trip(1'b0, -1, 1'b0, 1'b0);          // full-step trip
    run_trip(1'b1, -1, 1'b0, 1'b0);          // half-step, mode toggled mid-trip
    run_trip(1'b0, int'(2*SD + 1), 1'b0, 1'b0); // abort after 2 descend steps
    run_trip(1'b0, 0, 1'b0, 1'b0);           // abort before first step
    run_trip(1'b1, -1, 1'b1, 1'b0);          // abort held during ascend
    run_trip(1'b0, -1, 1'b0, 1'b1);          // second go edge while busy

    // Asynchronous reset mid-ASCEND
    s_ev = ev_coils.size();
    s_done = done_cnt;
    @(posedge clk); #1;
    go = 1'b0;
    tick(1);
    go = 1'b1;
    tick(DS*SD + PC + 3);
    #3 reset = 1'b1;
    #1;
    check("midreset_coils", 32'(coils), 32'(4'b1001));
    check("midreset_coils_hold0", 32'(coils0), 0);
    check("midreset_busy", 32'(busy), 0);
    check("midreset_position", 32'(position), 0);
    check("midreset_had_descended", ev_coils.size() - s_ev, DS);
    tick(2);
    reset = 1'b0;
    tick(2);
    check("midreset_no_done", done_cnt - s_done, 0);
    run_trip(1'b0, -1, 1'b0, 1'b0);

    // Randomized trips
    for (int t = 0; t < 10; t++) begin
      int unsigned sel;
      bit          m;
      m   = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 2);
      if (sel == 0)      run_trip(m, -1, 1'b0, 1'b0);
      else if (sel == 1) run_trip(m, int'($urandom_range(0, DS*SD + PC)), 1'b0, 1'b0);
      else               run_trip(m, -1, 1'b1, 1'b0);
      tick($urandom_range(1, 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
